wshb_fb_slave: RTL and testbench
================================

WSHB_FB_SLAVE -- requirements
Module: wshb_fb_slave

Interface
REQ-001 SHALL have parameter HDISP, default 800, pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, lines per frame; memory depth N = HDISP*VDISP 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..7, extra cycles inserted before each response.
REQ-004 SHALL connect one clock and an asynchronous, active-high reset: wshb_ifs.clk and wshb_ifs.rst, both carried on the Wishbone interface wshb_ifs (modport wshb_if.slave).
REQ-005 wshb_ifs.clk  input  1  sole clock; all state on rising edge.
REQ-006 wshb_ifs.rst  input  1  asynchronous active-high reset.
REQ-007 wshb_ifs.cyc  input  1  bus cycle in progress.
REQ-008 wshb_ifs.stb  input  1  transfer request.
REQ-009 wshb_ifs.we  input  1  1 = write, 0 = read.
REQ-010 wshb_ifs.sel  input  4  byte-lane enables.
REQ-011 wshb_ifs.adr  input  32  byte address; word index = adr[31:2].
REQ-012 wshb_ifs.dat_ms  input  32  write data.
REQ-013 wshb_ifs.dat_sm  output  32  read data.
REQ-014 wshb_ifs.ack  output  1  normal transfer termination.
REQ-015 wshb_ifs.err  output  1  error termination (out-of-range address).
REQ-016 frame_done  output  1  one-cycle pulse after the last word of the frame is written.
REQ-017 wr_count  output  32  count of committed write transfers.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-019 IDLE: on cyc&stb SHALL latch adr, we, sel, dat_ms; go to RESP if WAIT_STATES=0, else load wait counter with WAIT_STATES and go to WAIT.
REQ-020 WAIT: SHALL decrement counter each cycle; go to RESP on the cycle the counter reaches 1.
REQ-021 RESP: SHALL last exactly one cycle, then return to IDLE unconditionally; a new request is not accepted in the RESP cycle.
REQ-022 Latency: ack/err SHALL be high exactly WAIT_STATES+1 cycles after the edge on which the request was latched; max throughput is one transfer per WAIT_STATES+2 cycles.
REQ-023 In RESP, ack = cyc & in-range, err = cyc & out-of-range; never both high; both low in IDLE and WAIT.
REQ-024 In-range means word index < N; out-of-range SHALL not modify memory or wr_count and SHALL return dat_sm = 0.
REQ-025 Write commit SHALL occur on the edge ending the RESP cycle when ack=1, updating only byte lanes with sel[i]=1; sel=4'b0000 still acks and counts as committed.
REQ-026 Read: dat_sm SHALL hold the memory word at the latched index during RESP (in-range, we=0), 0 otherwise; memory is synchronous-read RAM.
REQ-027 If cyc falls during WAIT or RESP, the transfer SHALL be aborted: FSM to IDLE, no ack/err, no write, no counter change.
REQ-028 wr_count SHALL increment by 1 per committed write and wrap from 2^32-1 to 0.
REQ-029 frame_done SHALL pulse high for one cycle, the cycle after a committed write to word index N-1; repeated writes to N-1 pulse each time.
REQ-030 stb held high continuously (master re-presenting after ack) SHALL be treated as a new request only when sampled in IDLE.

Reset
REQ-031 While rst=1, regardless of clock: FSM = IDLE, ack = 0, err = 0, dat_sm = 0, frame_done = 0, wr_count = 0, wait counter = 0.
REQ-032 Memory contents SHALL NOT be reset; reads before any write return undefined data.
REQ-033 Reset asserted mid-transfer SHALL abort it with no write and no termination; first request after rst falls is sampled on the first rising edge with rst=0.

Verification
REQ-034 WAIT_STATES=0, write adr=0x0, dat=0x00FFFFFF, sel=4'b0111 then read adr=0x0 -> ack one cycle after each request, read dat_sm=0x00FFFFFF, wr_count=1.
REQ-035 HDISP=4, VDISP=2, stb held high for 8 sequential writes adr 0x00..0x1C -> 8 acks at 2-cycle spacing, frame_done one pulse after 8th commit, wr_count=8.
REQ-036 WAIT_STATES=3, read in-range -> ack exactly 4 cycles after latch; cyc dropped in cycle 2 of WAIT -> no ack, no write.
REQ-037 Write adr=4*N -> err=1 one cycle, ack=0, memory and wr_count unchanged.
REQ-038 Write 0xAABBCCDD sel=4'b1111, then 0x11223344 sel=4'b0101, then read -> 0xAA22CC44.
REQ-039 rst asserted asynchronously mid-WAIT -> ack, err, frame_done, dat_sm immediately 0; target word unchanged.

Source files
------------

// File: rtl/wshb_fb_slave_if.sv
// Wishbone classic bus bundle for the frame-buffer slave; clk/rst travel with the bus.
// Handshake: a request is cyc&stb sampled while the slave is idle; it ends with exactly one ack or err cycle, or silently if cyc drops first.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;

  modport master (
    input  clk, rst,
    output cyc, stb, we, sel, adr, dat_ms,
    input  dat_sm, ack, err
  );

  modport slave (
    input  clk, rst,
    input  cyc, stb, we, sel, adr, dat_ms,
    output dat_sm, ack, err
  );
endinterface

// File: rtl/wshb_fb_slave.sv
// Wishbone frame-buffer slave: HDISP*VDISP words of byte-writable RAM with programmable wait states,
// a committed-write counter and a pulse when the last pixel of the frame is written.
module wshb_fb_slave #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int WAIT_STATES = 0
) (
  wshb_if.slave       wshb_ifs,
  output logic        frame_done,
  output logic [31:0] wr_count,
  output logic [1:0]  state_dbg
);
  localparam int          N    = HDISP * VDISP;
  localparam int          AW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [29:0] NW   = 30'(N);
  localparam logic [29:0] LAST = 30'(N - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [29:0] idx_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        in_range_q;
  logic        rd_valid;
  logic [31:0] rd_word;
  logic [31:0] mem [0:N-1];

  logic        req;
  logic        in_range_in;
  logic [29:0] rd_idx;
  logic        rd_ok;
  logic        enter_resp;
  logic        commit;

  always_comb begin
    req         = wshb_ifs.cyc & wshb_ifs.stb;
    in_range_in = wshb_ifs.adr[31:2] < NW;
    rd_idx      = (state == IDLE) ? wshb_ifs.adr[31:2] : idx_q;
    rd_ok       = (state == IDLE) ? (in_range_in & ~wshb_ifs.we) : (in_range_q & ~we_q);
    enter_resp  = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                  ((state == WAIT) && wshb_ifs.cyc && (cnt == 3'd1));
    commit      = (state == RESP) && wshb_ifs.cyc && in_range_q && we_q;
  end

  // Termination follows cyc live, so a master that withdraws in RESP sees no ack/err.
  assign wshb_ifs.ack    = (state == RESP) & wshb_ifs.cyc & in_range_q;
  assign wshb_ifs.err    = (state == RESP) & wshb_ifs.cyc & ~in_range_q;
  assign wshb_ifs.dat_sm = ((state == RESP) && rd_valid) ? rd_word : 32'h0;
  assign state_dbg       = state;

  logic unused_bits;
  assign unused_bits = ^{wshb_ifs.adr[1:0], rd_idx};

  always_ff @(posedge wshb_ifs.clk or posedge wshb_ifs.rst) begin
    if (wshb_ifs.rst) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      idx_q      <= 30'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      dat_q      <= 32'd0;
      in_range_q <= 1'b0;
      rd_valid   <= 1'b0;
      frame_done <= 1'b0;
      wr_count   <= 32'd0;
    end else begin
      rd_valid   <= enter_resp && rd_ok;
      frame_done <= commit && (idx_q == LAST);
      if (commit) wr_count <= wr_count + 32'd1;
      case (state)
        IDLE: if (req) begin
          idx_q      <= wshb_ifs.adr[31:2];
          we_q       <= wshb_ifs.we;
          sel_q      <= wshb_ifs.sel;
          dat_q      <= wshb_ifs.dat_ms;
          in_range_q <= in_range_in;
          if (WAIT_STATES == 0) begin
            state <= RESP;
          end else begin
            cnt   <= 3'(WAIT_STATES);
            state <= WAIT;
          end
        end
        WAIT: if (!wshb_ifs.cyc) begin
          state <= IDLE;
          cnt   <= 3'd0;
        end else if (cnt == 3'd1) begin
          state <= RESP;
          cnt   <= 3'd0;
        end else begin
          cnt <= cnt - 3'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Frame RAM is not reset; the read port runs every cycle and rd_valid qualifies it.
  always_ff @(posedge wshb_ifs.clk) begin
    rd_word <= mem[rd_idx[AW-1:0]];
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_q[i]) mem[idx_q[AW-1:0]][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_wshb_fb_slave.sv
// Directed bench for wshb_fb_slave: one zero-wait instance and one three-wait instance on an 8-word frame.
module tb_wshb_fb_slave;
  logic clk;
  logic rst_a, rst_b;
  logic        frame_done_a, frame_done_b;
  logic [31:0] wr_count_a, wr_count_b;
  logic [1:0]  state_a, state_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_num = 0;
  int fd_cnt_a = 0;

  wshb_if bus_a (.clk(clk), .rst(rst_a));
  wshb_if bus_b (.clk(clk), .rst(rst_b));

  wshb_fb_slave #(.HDISP(4), .VDISP(2), .WAIT_STATES(0)) dut_a (
    .wshb_ifs(bus_a.slave), .frame_done(frame_done_a), .wr_count(wr_count_a), .state_dbg(state_a));
  wshb_fb_slave #(.HDISP(4), .VDISP(2), .WAIT_STATES(3)) dut_b (
    .wshb_ifs(bus_b.slave), .frame_done(frame_done_b), .wr_count(wr_count_b), .state_dbg(state_b));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_num <= cyc_num + 1;
  always @(negedge clk) if (frame_done_a) fd_cnt_a <= fd_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit b, input logic cyc, input logic stb, input logic we,
                       input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (b) begin
      bus_b.cyc = cyc; bus_b.stb = stb; bus_b.we = we; bus_b.sel = sel; bus_b.adr = adr; bus_b.dat_ms = dat;
    end else begin
      bus_a.cyc = cyc; bus_a.stb = stb; bus_a.we = we; bus_a.sel = sel; bus_a.adr = adr; bus_a.dat_ms = dat;
    end
  endtask

  function automatic logic [33:0] obs(input bit b);
    return b ? {bus_b.ack, bus_b.err, bus_b.dat_sm} : {bus_a.ack, bus_a.err, bus_a.dat_sm};
  endfunction

  // One transfer; lat is the number of cycles from the latching edge to the terminating cycle.
  task automatic xfer(input bit b, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic ack, output logic err,
                      output logic [31:0] rdata, output int lat);
    logic [33:0] o;
    bit done = 0;
    ack = 0; err = 0; rdata = 0; lat = 0;
    @(posedge clk); #1;
    drive(b, 1, 1, we, sel, adr, dat);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      o = obs(b);
      if (o[33] || o[32]) begin
        done = 1; ack = o[33]; err = o[32]; rdata = o[31:0];
      end
    end
    lat--;
    @(posedge clk); #1;
    drive(b, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    if (!done) check("timeout", 32'd0, 32'd1);
    check("ack_err_excl", 32'(ack & err), 32'd0);
  endtask

  logic        ack, err;
  logic [31:0] rd;
  int          lat;
  int          t_ack [8];
  int          fd0;
  bit          seen;

  initial begin
    rst_a = 1; rst_b = 1;
    drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    #3;
    check("rst_ack", 32'(bus_a.ack), 32'd0);
    check("rst_err", 32'(bus_a.err), 32'd0);
    check("rst_dat", bus_a.dat_sm, 32'd0);
    check("rst_fd", 32'(frame_done_a), 32'd0);
    check("rst_wrc", wr_count_a, 32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    check("rst_wrc_b", wr_count_b, 32'd0);
    repeat (3) @(posedge clk);
    #2; rst_a = 0; rst_b = 0;

    // zero-wait: basic write/read with partial byte enables
    xfer(0, 1, 32'h0, 32'h0, 4'hF, ack, err, rd, lat);
    check("w0_ack", 32'(ack), 32'd1);
    xfer(0, 1, 32'h0, 32'h00FFFFFF, 4'b0111, ack, err, rd, lat);
    check("w1_ack", 32'(ack), 32'd1);
    check("w1_lat", 32'(lat), 32'd1);
    check("w1_wrc", wr_count_a, 32'd2);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, ack, err, rd, lat);
    check("r1_ack", 32'(ack), 32'd1);
    check("r1_lat", 32'(lat), 32'd1);
    check("r1_dat", rd, 32'h00FFFFFF);
    check("r1_wrc", wr_count_a, 32'd2);

    xfer(0, 1, 32'h4, 32'hAABBCCDD, 4'hF, ack, err, rd, lat);
    xfer(0, 1, 32'h4, 32'h11223344, 4'b0101, ack, err, rd, lat);
    xfer(0, 0, 32'h4, 32'h0, 4'hF, ack, err, rd, lat);
    check("merge_dat", rd, 32'hAA22CC44);
    check("merge_wrc", wr_count_a, 32'd4);

    xfer(0, 1, 32'h8, 32'h12345678, 4'hF, ack, err, rd, lat);
    xfer(0, 1, 32'h8, 32'hFFFFFFFF, 4'h0, ack, err, rd, lat);
    check("sel0_ack", 32'(ack), 32'd1);
    check("sel0_wrc", wr_count_a, 32'd6);
    xfer(0, 0, 32'h8, 32'h0, 4'hF, ack, err, rd, lat);
    check("sel0_dat", rd, 32'h12345678);

    // out-of-range: first word past the frame and the top of the address space
    xfer(0, 1, 32'h20, 32'hBADBAD00, 4'hF, ack, err, rd, lat);
    check("oor_w_err", 32'(err), 32'd1);
    check("oor_w_ack", 32'(ack), 32'd0);
    check("oor_w_wrc", wr_count_a, 32'd6);
    xfer(0, 0, 32'h20, 32'h0, 4'hF, ack, err, rd, lat);
    check("oor_r_err", 32'(err), 32'd1);
    check("oor_r_dat", rd, 32'd0);
    xfer(0, 1, 32'hFFFFFFFC, 32'h0, 4'hF, ack, err, rd, lat);
    check("oor_top_err", 32'(err), 32'd1);
    xfer(0, 0, 32'h0, 32'h0, 4'hF, ack, err, rd, lat);
    check("oor_alias", rd, 32'h00FFFFFF);

    // stb held high: eight back-to-back writes across the whole frame
    fd0 = fd_cnt_a;
    @(posedge clk); #1;
    drive(0, 1, 1, 1, 4'hF, 32'h0, 32'hA0000000);
    for (int i = 0; i < 8; i++) begin
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (bus_a.ack) begin seen = 1; t_ack[i] = cyc_num; end
      end
      if (!seen) check("stream_timeout", 32'(i), 32'hFFFFFFFF);
      if (i > 0) check("stream_gap", 32'(t_ack[i] - t_ack[i-1]), 32'd2);
      if (i == 6) check("stream_fd_early", 32'(fd_cnt_a - fd0), 32'd0);
      @(posedge clk); #1;
      if (i < 7) drive(0, 1, 1, 1, 4'hF, 32'(4 * (i + 1)), 32'hA0000000 + 32'(i + 1));
      else drive(0, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    end
    @(negedge clk);
    #1;
    check("stream_fd_pulse", 32'(frame_done_a), 32'd1);
    @(negedge clk);
    #1;
    check("stream_fd_low", 32'(frame_done_a), 32'd0);
    check("stream_fd_cnt", 32'(fd_cnt_a - fd0), 32'd1);
    check("stream_wrc", wr_count_a, 32'd14);
    xfer(0, 0, 32'hC, 32'h0, 4'hF, ack, err, rd, lat);
    check("stream_rd3", rd, 32'hA0000003);
    xfer(0, 1, 32'h1C, 32'h77, 4'hF, ack, err, rd, lat);
    repeat (2) @(negedge clk);
    #1;
    check("fd_repeat", 32'(fd_cnt_a - fd0), 32'd2);
    check("fd_repeat_wrc", wr_count_a, 32'd15);

    // three wait states
    xfer(1, 1, 32'h8, 32'hCAFEF00D, 4'hF, ack, err, rd, lat);
    check("ws_w_ack", 32'(ack), 32'd1);
    check("ws_w_lat", 32'(lat), 32'd4);
    check("ws_w_wrc", wr_count_b, 32'd1);
    xfer(1, 0, 32'h8, 32'h0, 4'hF, ack, err, rd, lat);
    check("ws_r_lat", 32'(lat), 32'd4);
    check("ws_r_dat", rd, 32'hCAFEF00D);

    // cyc withdrawn in the second WAIT cycle
    @(posedge clk); #1;
    drive(1, 1, 1, 1, 4'hF, 32'h8, 32'hDEADBEEF);
    @(posedge clk);
    @(posedge clk); #1;
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_b.ack || bus_b.err) seen = 1;
    end
    check("abort_no_term", 32'(seen), 32'd0);
    check("abort_wrc", wr_count_b, 32'd1);
    xfer(1, 0, 32'h8, 32'h0, 4'hF, ack, err, rd, lat);
    check("abort_dat", rd, 32'hCAFEF00D);

    // asynchronous reset in the middle of WAIT
    @(posedge clk); #1;
    drive(1, 1, 1, 1, 4'hF, 32'h8, 32'h55555555);
    @(posedge clk);
    @(posedge clk); #3;
    rst_b = 1;
    #1;
    check("rstw_ack", 32'(bus_b.ack), 32'd0);
    check("rstw_err", 32'(bus_b.err), 32'd0);
    check("rstw_dat", bus_b.dat_sm, 32'd0);
    check("rstw_fd", 32'(frame_done_b), 32'd0);
    check("rstw_wrc", wr_count_b, 32'd0);
    check("rstw_state", 32'(state_b), 32'd0);
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #2;
    rst_b = 0;
    xfer(1, 0, 32'h8, 32'h0, 4'hF, ack, err, rd, lat);
    check("rstw_word", rd, 32'hCAFEF00D);
    check("rstw_wrc2", wr_count_b, 32'd0);

    // asynchronous reset while a read is being acknowledged
    @(posedge clk); #1;
    drive(1, 1, 1, 0, 4'hF, 32'h8, 32'h0);
    seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (bus_b.ack) seen = 1;
    end
    check("rstr_ack_before", 32'(seen), 32'd1);
    #1;
    rst_b = 1;
    #1;
    check("rstr_ack", 32'(bus_b.ack), 32'd0);
    check("rstr_dat", bus_b.dat_sm, 32'd0);
    drive(1, 0, 0, 0, 4'h0, 32'h0, 32'h0);
    @(posedge clk); #2;
    rst_b = 0;
    xfer(1, 0, 32'h8, 32'h0, 4'hF, ack, err, rd, lat);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_dat", rd, 32'hCAFEF00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
